// File: rtl/cmp_arb_pkg.sv
// Shared types and helpers for the comparator arbiter slice.
//   cmp_res_t : one comparison result {eq, lt (signed), ltu (unsigned)}
//   idw()     : index width for a requester count ($clog2, minimum 1)
// The per-stage operand struct depends on WIDTH/NREQ, so it is declared
// inside cmp_arbiter where those parameters are known.
package cmp_arb_pkg;

  typedef struct packed {
    logic eq;
    logic lt;
    logic ltu;
  } cmp_res_t;

  function automatic int unsigned idw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmp_arb_rr.sv
// Round-robin grant search: first set bit of req at or after ptr, wrapping.
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   gnt_c     : one-hot grant (all zero when no request)
//   gnt_idx_c : binary index of the granted requester
//   any_c     : at least one request present
module rr_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = idw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_c,
  output logic [IDW-1:0]  gnt_idx_c,
  output logic            any_c
);

  // NREQ is a power of two, so IDW-bit addition wraps modulo NREQ.
  always_comb begin
    logic [IDW-1:0] idx;
    gnt_c     = '0;
    gnt_idx_c = '0;
    any_c     = 1'b0;
    idx       = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = ptr + IDW'(i);
      if (!any_c && req[idx]) begin
        any_c      = 1'b1;
        gnt_idx_c  = idx;
        gnt_c[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/comparatortree.sv
// Shared combinational comparator: equality, signed and unsigned less-than.
//   a, b : WIDTH-bit operands
//   eq   : a == b
//   lt   : a <  b (two's complement)
//   ltu  : a <  b (unsigned)
module comparatortree #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             lt,
  output logic             ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin front end sharing one comparatortree among NREQ requesters,
// with a 2-stage valid/ready pipeline (operands, then results) and a
// saturating count of results accepted downstream.
//   req_valid/req_ready       : per-requester handshake (ready is one-hot or 0)
//   req_op1/req_op2           : flattened operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready       : result handshake
//   rsp_id/rsp_eq/lt/ltu      : owner index and comparison result
//   done_cnt                  : completed results, saturating
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNTW  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_op1,
  input  logic [NREQ*WIDTH-1:0]   req_op2,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [idw(NREQ)-1:0]    rsp_id,
  output logic                    rsp_eq,
  output logic                    rsp_lt,
  output logic                    rsp_ltu,
  output logic [CNTW-1:0]         done_cnt
);

  localparam int unsigned IDW = idw(NREQ);

  typedef struct packed {
    logic             valid;
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
  } stage_t;

  stage_t         s1_q;
  logic           s2_v;
  logic [IDW-1:0] s2_id;
  cmp_res_t       s2_res;
  logic [IDW-1:0] rr_ptr;

  logic [NREQ-1:0] gnt_c;
  logic [IDW-1:0]  gnt_idx_c;
  logic            any_c;
  logic            adv1, adv2, accept;
  cmp_res_t        cmp_c;

  assign adv2 = !s2_v || rsp_ready;
  assign adv1 = !s1_q.valid || adv2;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt_c     (gnt_c),
    .gnt_idx_c (gnt_idx_c),
    .any_c     (any_c)
  );

  // Grant is held off while in reset so nothing is offered before the pipe is live.
  assign req_ready = (reset_n && adv1) ? gnt_c : '0;
  assign accept    = any_c && adv1 && reset_n;

  comparatortree #(.WIDTH(WIDTH)) u_cmp (
    .a   (s1_q.op1),
    .b   (s1_q.op2),
    .eq  (cmp_c.eq),
    .lt  (cmp_c.lt),
    .ltu (cmp_c.ltu)
  );

  // Stage 1: operand capture and round-robin pointer update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      s1_q.valid <= 1'b1;
      s1_q.id    <= gnt_idx_c;
      s1_q.op1   <= req_op1[int'(gnt_idx_c)*int'(WIDTH) +: WIDTH];
      s1_q.op2   <= req_op2[int'(gnt_idx_c)*int'(WIDTH) +: WIDTH];
      rr_ptr     <= gnt_idx_c + IDW'(1);
    end else if (adv1) begin
      s1_q.valid <= 1'b0;
    end
  end

  // Stage 2: comparison result register; holds under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_v   <= 1'b0;
      s2_id  <= '0;
      s2_res <= '0;
    end else if (adv2) begin
      if (s1_q.valid) begin
        s2_v   <= 1'b1;
        s2_id  <= s1_q.id;
        s2_res <= cmp_c;
      end else begin
        s2_v <= 1'b0;
      end
    end
  end

  // Completed-result counter, sticks at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_cnt <= '0;
    end else if (s2_v && rsp_ready && (done_cnt != {CNTW{1'b1}})) begin
      done_cnt <= done_cnt + CNTW'(1);
    end
  end

  assign rsp_valid = s2_v;
  assign rsp_id    = s2_id;
  assign rsp_eq    = s2_res.eq;
  assign rsp_lt    = s2_res.lt;
  assign rsp_ltu   = s2_res.ltu;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Bench for cmp_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model (capacity 2, latency 2, round-robin order).
module tb_cmp_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned IDW   = 2;

  logic clk = 1'b0;
  logic reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_op1, req_op2;
  logic                  rsp_ready;

  logic [NREQ-1:0] req_ready, req_ready4;
  logic            rsp_valid, rsp_valid4;
  logic [IDW-1:0]  rsp_id, rsp_id4;
  logic            rsp_eq, rsp_lt, rsp_ltu, rsp_eq4, rsp_lt4, rsp_ltu4;
  logic [15:0]     done_cnt;
  logic [3:0]      done_cnt4;

  always #5 clk = ~clk;

  cmp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(16)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt), .rsp_ltu(rsp_ltu),
    .done_cnt(done_cnt)
  );

  cmp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready4),
    .req_op1(req_op1), .req_op2(req_op2), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id4), .rsp_eq(rsp_eq4), .rsp_lt(rsp_lt4), .rsp_ltu(rsp_ltu4),
    .done_cnt(done_cnt4)
  );

  // Reference model: in-flight results in order, with edges elapsed since accept.
  typedef struct {
    logic [IDW-1:0] id;
    logic           eq;
    logic           lt;
    logic           ltu;
    int             age;
  } exp_t;

  exp_t q[$];
  int   m_rr;
  int   m_cnt;
  int   total = 0;
  int   bad   = 0;

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < int'(NREQ); k++) begin
      int j;
      j = (ptr + k) % int'(NREQ);
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic m_rsp_valid();
    return (q.size() > 0) && (q[0].age >= 2);
  endfunction

  function automatic logic [NREQ-1:0] exp_ready();
    int g;
    g = pick(req_valid, m_rr);
    if (g < 0) return '0;
    if (!((q.size() < 2) || rsp_ready)) return '0;
    return NREQ'(1) << g;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic set_req(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_op1[i*WIDTH +: WIDTH] = a;
    req_op2[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic clear_model();
    q.delete();
    m_rr  = 0;
    m_cnt = 0;
  endtask

  // Advance one clock; the model consumes the inputs present before the edge.
  task automatic step();
    logic            hs;
    logic [NREQ-1:0] er;
    int              g;
    logic [WIDTH-1:0] a, b;
    exp_t            e;
    hs = m_rsp_valid() && rsp_ready;
    er = exp_ready();
    g  = pick(req_valid, m_rr);
    if (g >= 0) begin
      a = req_op1[g*WIDTH +: WIDTH];
      b = req_op2[g*WIDTH +: WIDTH];
    end else begin
      a = '0;
      b = '0;
    end
    @(posedge clk);
    if (hs) begin
      void'(q.pop_front());
      m_cnt++;
    end
    foreach (q[i]) q[i].age++;
    if (er != '0) begin
      e.id  = IDW'(g);
      e.eq  = (a == b);
      e.lt  = ($signed(a) < $signed(b));
      e.ltu = (a < b);
      e.age = 1;
      q.push_back(e);
      m_rr = (g + 1) % int'(NREQ);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    req_valid = '0;
    rsp_ready = 1'b0;
    reset_n   = 1'b0;
    #1;
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_op1   = '0;
    req_op2   = '0;
    clear_model();
    repeat (4) begin
      @(negedge clk);
      #1;
      total++;
      if (req_ready !== 4'b0000) begin
        bad++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
      end
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
      end
      total++;
      if (done_cnt !== 16'd0) begin
        bad++; $display("FAIL reset_done_cnt: got %0d want 0", done_cnt);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL reset_first_grant: got %b want 0001", req_ready);
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    set_req(2, 32'hFFFF_FFFF, 32'h0000_0001);
    rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready: got %b want 0100", req_ready);
    end
    step();
    req_valid = '0;
    #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_early_valid: got %b want 0", rsp_valid);
    end
    step();
    #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu} !== {1'b1, 2'd2, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL single_result: got v=%b id=%0d eq=%b lt=%b ltu=%b want v=1 id=2 eq=0 lt=1 ltu=0",
               rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu);
    end
    step();
    #1;
    total++;
    if (done_cnt !== 16'd1) begin
      bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt);
    end
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++; $display("FAIL single_drained: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 32'h1234_5678, 32'h1234_5678);
    rsp_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      req_valid = (k < 5) ? 4'b1111 : 4'b0000;
      #1;
      if (k < 5) begin
        total++;
        if (req_ready !== (4'b0001 << (k % 4))) begin
          bad++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, 4'b0001 << (k % 4));
        end
      end
      if (k >= 2) begin
        total++;
        if ({rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu} !== {1'b1, IDW'((k - 2) % 4), 1'b1, 1'b0, 1'b0}) begin
          bad++;
          $display("FAIL rr_rsp[%0d]: got v=%b id=%0d eq=%b lt=%b ltu=%b want v=1 id=%0d eq=1 lt=0 ltu=0",
                   k, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu, (k - 2) % 4);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    set_req(1, 32'd5, 32'd5);
    set_req(3, 32'hFFFF_FFFD, 32'd2);
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    #1;
    step();
    req_valid = 4'b1000;
    #1;
    step();
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (req_ready !== 4'b0000) begin
        bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, req_ready);
      end
      total++;
      if ({rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu} !== {1'b1, 2'd1, 1'b1, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d eq=%b lt=%b ltu=%b want v=1 id=1 eq=1 lt=0 ltu=0",
                 k, rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu);
      end
      step();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    #1;
    step();
    #1;
    total++;
    if ({rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu} !== {1'b1, 2'd3, 1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL bp_second: got v=%b id=%0d eq=%b lt=%b ltu=%b want v=1 id=3 eq=0 lt=1 ltu=0",
               rsp_valid, rsp_id, rsp_eq, rsp_lt, rsp_ltu);
    end
    step();
    #1;
    total++;
    if ({rsp_valid, done_cnt} !== {1'b0, 16'd2}) begin
      bad++; $display("FAIL bp_drain: got v=%b cnt=%0d want v=0 cnt=2", rsp_valid, done_cnt);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_req(0, 32'd1, 32'd2);
    set_req(1, 32'd3, 32'd3);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    step();
    req_valid = 4'b0010;
    #1;
    step();
    req_valid = '0;
    @(posedge clk);
    #2;
    total++;
    if (rsp_valid !== 1'b1) begin
      bad++; $display("FAIL areset_full: got %b want 1", rsp_valid);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, req_ready} !== 5'b0_0000) begin
      bad++; $display("FAIL areset_drop: got v=%b ready=%b want v=0 ready=0000", rsp_valid, req_ready);
    end
    clear_model();
    @(negedge clk);
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++; $display("FAIL areset_stale[%0d]: got %b want 0", k, rsp_valid);
      end
      step();
    end
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++; $display("FAIL areset_ptr: got %b want 0001", req_ready);
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_saturation();
    apply_reset();
    set_req(2, 32'd7, 32'd9);
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    for (int c = 0; c < 40 && m_cnt < 20; c++) begin
      #1;
      step();
    end
    req_valid = '0;
    #1;
    total++;
    if (done_cnt !== 16'd20) begin
      bad++; $display("FAIL sat_cnt16: got %0d want 20", done_cnt);
    end
    total++;
    if (done_cnt4 !== 4'd15) begin
      bad++; $display("FAIL sat_cnt4: got %0d want 15", done_cnt4);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      logic [NREQ-1:0] er;
      logic            ev;
      if (c < 395) begin
        req_valid = NREQ'($urandom_range(15));
        rsp_ready = ($urandom_range(3) != 0);
        for (int i = 0; i < int'(NREQ); i++) begin
          logic [WIDTH-1:0] a, b;
          a = (($urandom_range(1) == 0)) ? WIDTH'($urandom) : WIDTH'($urandom_range(8)) - WIDTH'(4);
          b = ($urandom_range(3) == 0) ? a :
              (($urandom_range(1) == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(8)) - WIDTH'(4));
          set_req(i, a, b);
        end
      end else begin
        req_valid = '0;
        rsp_ready = 1'b1;
      end
      #1;
      er = exp_ready();
      ev = m_rsp_valid();
      total++;
      if ({req_ready, req_ready4} !== {er, er}) begin
        bad++; $display("FAIL rnd_ready[%0d]: got %b/%b want %b", c, req_ready, req_ready4, er);
      end
      total++;
      if ({rsp_valid, rsp_valid4} !== {ev, ev}) begin
        bad++; $display("FAIL rnd_valid[%0d]: got %b/%b want %b", c, rsp_valid, rsp_valid4, ev);
      end
      if (ev) begin
        total++;
        if ({rsp_id, rsp_eq, rsp_lt, rsp_ltu, rsp_id4, rsp_eq4, rsp_lt4, rsp_ltu4} !==
            {q[0].id, q[0].eq, q[0].lt, q[0].ltu, q[0].id, q[0].eq, q[0].lt, q[0].ltu}) begin
          bad++;
          $display("FAIL rnd_rsp[%0d]: got id=%0d eq=%b lt=%b ltu=%b want id=%0d eq=%b lt=%b ltu=%b",
                   c, rsp_id, rsp_eq, rsp_lt, rsp_ltu, q[0].id, q[0].eq, q[0].lt, q[0].ltu);
        end
      end
      total++;
      if ({done_cnt, done_cnt4} !== {16'(sat(m_cnt, 65535)), 4'(sat(m_cnt, 15))}) begin
        bad++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", c, done_cnt, done_cnt4,
                        sat(m_cnt, 65535), sat(m_cnt, 15));
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    rsp_ready = 1'b0;
    req_op1   = '0;
    req_op2   = '0;
    reset_n   = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_async_reset();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
